// File: rtl/reg_bank_param.sv
// reg_bank_param
// Parametrised register file with one write port, two registered read ports
// and a sequenced bulk-clear engine that walks every register to zero.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   write    write enable
//   dr       destination register address
//   wrData   write data
//   Sr1/Sr2  read addresses for ports 1 and 2
//   rdData1  registered read data, port 1 (one cycle after Sr1)
//   rdData2  registered read data, port 2 (one cycle after Sr2)
//   clear    request a clear sequence
//   busy     high while the clear sequence runs
//   done     one-cycle pulse on the edge that finishes the clear sequence
module reg_bank_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write,
    input  logic [ADDR_W-1:0] dr,
    input  logic [WIDTH-1:0]  wrData,
    input  logic [ADDR_W-1:0] Sr1,
    input  logic [ADDR_W-1:0] Sr2,
    output logic [WIDTH-1:0]  rdData1,
    output logic [WIDTH-1:0]  rdData2,
    input  logic              clear,
    output logic              busy,
    output logic              done
);

    // DEPTH need not be a power of two, so address range checks compare
    // against DEPTH in a width one bit wider than the address.
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [WIDTH-1:0]  regs [DEPTH];

    logic              wrAccept;
    logic [WIDTH-1:0]  rdNext1;
    logic [WIDTH-1:0]  rdNext2;

    // Decide whether this edge's write lands and what each read port will
    // capture. A clear request in the same cycle wins over the write.
    always_comb begin
        wrAccept = write && !clear && (state == IDLE)
                   && ({1'b0, dr} < DEPTH_X)
                   && !((ZERO_REG != 0) && (dr == '0));

        rdNext1 = '0;
        if (({1'b0, Sr1} < DEPTH_X) && !((ZERO_REG != 0) && (Sr1 == '0)))
            rdNext1 = regs[Sr1];
        if ((BYPASS != 0) && wrAccept && (dr == Sr1))
            rdNext1 = wrData;

        rdNext2 = '0;
        if (({1'b0, Sr2} < DEPTH_X) && !((ZERO_REG != 0) && (Sr2 == '0)))
            rdNext2 = regs[Sr2];
        if ((BYPASS != 0) && wrAccept && (dr == Sr2))
            rdNext2 = wrData;
    end

    // Storage, read registers and the clear sequencer share one block so the
    // clear engine and the write port can never drive a register together.
    // Read outputs are loaded with zero on the entry edge and on every clear
    // edge, so they read 0 for every cycle busy is high and also in the
    // cycle done is pulsed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdData1 <= '0;
            rdData2 <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear) begin
                        state   <= CLEAR;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        rdData1 <= '0;
                        rdData2 <= '0;
                    end else begin
                        if (wrAccept)
                            regs[dr] <= wrData;
                        rdData1 <= rdNext1;
                        rdData2 <= rdNext2;
                    end
                end
                CLEAR: begin
                    regs[cnt] <= '0;
                    rdData1   <= '0;
                    rdData2   <= '0;
                    if (cnt == LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_param.sv
// tb_reg_bank_param
// Drives three reg_bank_param instances from shared inputs:
//   inst0: DEPTH=8, ZERO_REG=0, BYPASS=1
//   inst1: DEPTH=8, ZERO_REG=1, BYPASS=0
//   inst2: DEPTH=6, ZERO_REG=0, BYPASS=1
// and compares each against its own behavioural model.
module tb_reg_bank_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write = 1'b0;
    logic        clear = 1'b0;
    logic [2:0]  dr = '0;
    logic [2:0]  Sr1 = '0;
    logic [2:0]  Sr2 = '0;
    logic [31:0] wrData = '0;

    logic [2:0][31:0] gotRd1;
    logic [2:0][31:0] gotRd2;
    logic [2:0]       gotBusy;
    logic [2:0]       gotDone;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_bank_param #(.WIDTH(32), .DEPTH(8), .ZERO_REG(0), .BYPASS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .write(write), .dr(dr), .wrData(wrData),
        .Sr1(Sr1), .Sr2(Sr2), .rdData1(gotRd1[0]), .rdData2(gotRd2[0]),
        .clear(clear), .busy(gotBusy[0]), .done(gotDone[0]));

    reg_bank_param #(.WIDTH(32), .DEPTH(8), .ZERO_REG(1), .BYPASS(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .write(write), .dr(dr), .wrData(wrData),
        .Sr1(Sr1), .Sr2(Sr2), .rdData1(gotRd1[1]), .rdData2(gotRd2[1]),
        .clear(clear), .busy(gotBusy[1]), .done(gotDone[1]));

    reg_bank_param #(.WIDTH(32), .DEPTH(6), .ZERO_REG(0), .BYPASS(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .write(write), .dr(dr), .wrData(wrData),
        .Sr1(Sr1), .Sr2(Sr2), .rdData1(gotRd1[2]), .rdData2(gotRd2[2]),
        .clear(clear), .busy(gotBusy[2]), .done(gotDone[2]));

    // Reference model: register contents plus the number of clear cycles left.
    int          pDepth [3] = '{8, 8, 6};
    int          pZero  [3] = '{0, 1, 0};
    int          pByp   [3] = '{1, 0, 1};
    logic [31:0] mMem   [3][8];
    int          mLeft  [3];
    logic [31:0] eRd1   [3];
    logic [31:0] eRd2   [3];
    logic        eBusy  [3];
    logic        eDone  [3];

    function automatic logic [31:0] modelRead(int i, logic [2:0] a);
        if (int'(a) >= pDepth[i] || (pZero[i] != 0 && a == 3'd0))
            return 32'd0;
        return mMem[i][a];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 3; i++) begin
            for (int a = 0; a < 8; a++)
                mMem[i][a] = 32'd0;
            mLeft[i] = 0;
            eRd1[i]  = 32'd0;
            eRd2[i]  = 32'd0;
            eBusy[i] = 1'b0;
            eDone[i] = 1'b0;
        end
    endtask

    // One rising edge of the model: a clear occupies DEPTH cycles, after
    // which the whole bank is zero; otherwise a normal read/write cycle.
    task automatic modelEdge();
        logic acc;
        for (int i = 0; i < 3; i++) begin
            eDone[i] = 1'b0;
            if (mLeft[i] > 0) begin
                mLeft[i] = mLeft[i] - 1;
                eRd1[i]  = 32'd0;
                eRd2[i]  = 32'd0;
                if (mLeft[i] == 0) begin
                    eDone[i] = 1'b1;
                    for (int a = 0; a < 8; a++)
                        mMem[i][a] = 32'd0;
                end
                eBusy[i] = (mLeft[i] > 0);
            end else if (clear) begin
                mLeft[i] = pDepth[i];
                eBusy[i] = 1'b1;
                eRd1[i]  = 32'd0;
                eRd2[i]  = 32'd0;
            end else begin
                acc = write && (int'(dr) < pDepth[i]) && !(pZero[i] != 0 && dr == 3'd0);
                eRd1[i] = (pByp[i] != 0 && acc && dr == Sr1) ? wrData : modelRead(i, Sr1);
                eRd2[i] = (pByp[i] != 0 && acc && dr == Sr2) ? wrData : modelRead(i, Sr2);
                if (acc)
                    mMem[i][dr] = wrData;
                eBusy[i] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n)
            modelEdge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        modelReset();
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (gotRd1[i] !== 32'd0 || gotRd2[i] !== 32'd0 || gotBusy[i] !== 1'b0 || gotDone[i] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_state inst%0d: got rd1=%h rd2=%h busy=%b done=%b, expected all 0",
                         i, gotRd1[i], gotRd2[i], gotBusy[i], gotDone[i]);
            end
        end
        rst_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            Sr1 = 3'(a);
            Sr2 = 3'(7 - a);
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (gotRd1[i] !== 32'd0 || gotRd2[i] !== 32'd0) begin
                    errors++;
                    $display("[TB] FAIL reset_read inst%0d addr%0d: got %h/%h expected 0/0", i, a, gotRd1[i], gotRd2[i]);
                end
            end
        end
        // Fill the bank, then pull reset in the middle of a cycle.
        write = 1'b1;
        for (int a = 0; a < 8; a++) begin
            dr = 3'(a);
            wrData = $urandom | 32'h1;
            tick();
        end
        write = 1'b0;
        Sr1 = 3'd5;
        Sr2 = 3'd1;
        tick();
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (gotRd1[i] !== 32'd0 || gotRd2[i] !== 32'd0 || gotBusy[i] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL async_reset inst%0d: got rd1=%h rd2=%h busy=%b, expected 0",
                         i, gotRd1[i], gotRd2[i], gotBusy[i]);
            end
        end
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        write = 1'b1;
        dr = 3'd5;
        wrData = 32'hDEADBEEF;
        tick();
        write = 1'b0;
        Sr1 = 3'd5;
        Sr2 = 3'd5;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (gotRd1[i] !== 32'hDEADBEEF || gotRd2[i] !== 32'hDEADBEEF) begin
                errors++;
                $display("[TB] FAIL write_read inst%0d: got %h/%h expected deadbeef", i, gotRd1[i], gotRd2[i]);
            end
        end
        // dr=7 lies outside the 6-deep instance.
        write = 1'b1;
        dr = 3'd7;
        wrData = 32'hCAFE0007;
        tick();
        write = 1'b0;
        Sr1 = 3'd7;
        Sr2 = 3'd7;
        tick();
        checks++;
        if (gotRd1[2] !== 32'd0) begin
            errors++;
            $display("[TB] FAIL out_of_range inst2: got %h expected 0", gotRd1[2]);
        end
        checks++;
        if (gotRd1[0] !== 32'hCAFE0007) begin
            errors++;
            $display("[TB] FAIL in_range_r7 inst0: got %h expected cafe0007", gotRd1[0]);
        end
    endtask

    task automatic test_bypass();
        write = 1'b1;
        dr = 3'd3;
        wrData = 32'hAAAA0000;
        tick();
        dr = 3'd2;
        wrData = $urandom;
        tick();
        dr = 3'd3;
        wrData = 32'h12345678;
        Sr1 = 3'd3;
        Sr2 = 3'd2;
        tick();
        write = 1'b0;
        checks++;
        if (gotRd1[0] !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL bypass_on inst0: got %h expected 12345678", gotRd1[0]);
        end
        checks++;
        if (gotRd1[1] !== 32'hAAAA0000) begin
            errors++;
            $display("[TB] FAIL bypass_off inst1: got %h expected aaaa0000", gotRd1[1]);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (gotRd1[i] !== eRd1[i] || gotRd2[i] !== eRd2[i]) begin
                errors++;
                $display("[TB] FAIL bypass_model inst%0d: got %h/%h expected %h/%h", i, gotRd1[i], gotRd2[i], eRd1[i], eRd2[i]);
            end
        end
        tick();
        checks++;
        if (gotRd1[1] !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL bypass_off_next inst1: got %h expected 12345678", gotRd1[1]);
        end
    endtask

    task automatic test_zero_reg();
        write = 1'b1;
        dr = 3'd0;
        wrData = 32'hFFFFFFFF;
        tick();
        dr = 3'd1;
        tick();
        write = 1'b0;
        Sr1 = 3'd0;
        Sr2 = 3'd1;
        tick();
        checks++;
        if (gotRd1[1] !== 32'd0 || gotRd2[1] !== 32'hFFFFFFFF) begin
            errors++;
            $display("[TB] FAIL zero_reg inst1: got %h/%h expected 0/ffffffff", gotRd1[1], gotRd2[1]);
        end
        checks++;
        if (gotRd1[0] !== 32'hFFFFFFFF) begin
            errors++;
            $display("[TB] FAIL no_zero_reg inst0: got %h expected ffffffff", gotRd1[0]);
        end
    endtask

    task automatic test_clear();
        int busyCnt [3];
        int doneCnt [3];
        int expCnt  [3] = '{8, 8, 6};
        write = 1'b1;
        for (int a = 0; a < 8; a++) begin
            dr = 3'(a);
            wrData = $urandom | 32'h100;
            tick();
        end
        // Clear and write in the same cycle: the write must be lost.
        clear = 1'b1;
        dr = 3'd4;
        wrData = 32'h5555AAAA;
        Sr1 = 3'd4;
        Sr2 = 3'd1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            busyCnt[i] = gotBusy[i] ? 1 : 0;
            doneCnt[i] = 0;
        end
        for (int c = 0; c < 12; c++) begin
            clear = (c == 1);
            write = (c < 3);
            wrData = $urandom;
            tick();
            for (int i = 0; i < 3; i++) begin
                if (gotBusy[i]) busyCnt[i]++;
                if (gotDone[i]) doneCnt[i]++;
                checks++;
                if (gotRd1[i] !== eRd1[i] || gotRd2[i] !== eRd2[i] || gotBusy[i] !== eBusy[i] || gotDone[i] !== eDone[i]) begin
                    errors++;
                    $display("[TB] FAIL clear_cycle inst%0d c%0d: got rd=%h/%h busy=%b done=%b expected %h/%h %b %b",
                             i, c, gotRd1[i], gotRd2[i], gotBusy[i], gotDone[i], eRd1[i], eRd2[i], eBusy[i], eDone[i]);
                end
            end
        end
        clear = 1'b0;
        write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busyCnt[i] !== expCnt[i] || doneCnt[i] !== 1) begin
                errors++;
                $display("[TB] FAIL clear_length inst%0d: got busy=%0d done=%0d expected busy=%0d done=1",
                         i, busyCnt[i], doneCnt[i], expCnt[i]);
            end
        end
        for (int a = 0; a < 8; a++) begin
            Sr1 = 3'(a);
            Sr2 = 3'(a);
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (gotRd1[i] !== 32'd0 || gotRd2[i] !== 32'd0) begin
                    errors++;
                    $display("[TB] FAIL after_clear inst%0d r%0d: got %h/%h expected 0", i, a, gotRd1[i], gotRd2[i]);
                end
            end
        end
    endtask

    task automatic test_clear_held();
        int doneCnt [3];
        for (int i = 0; i < 3; i++) doneCnt[i] = 0;
        clear = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                if (gotDone[i]) doneCnt[i]++;
                checks++;
                if (gotBusy[i] !== eBusy[i] || gotDone[i] !== eDone[i]) begin
                    errors++;
                    $display("[TB] FAIL clear_held inst%0d c%0d: got busy=%b done=%b expected %b %b",
                             i, c, gotBusy[i], gotDone[i], eBusy[i], eDone[i]);
                end
            end
        end
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (doneCnt[i] !== 2) begin
                errors++;
                $display("[TB] FAIL clear_held_done inst%0d: got %0d pulses expected 2", i, doneCnt[i]);
            end
        end
        repeat (10) tick();
    endtask

    task automatic test_reset_mid_clear();
        write = 1'b1;
        for (int a = 0; a < 8; a++) begin
            dr = 3'(a);
            wrData = $urandom | 32'h1000;
            tick();
        end
        write = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (gotBusy[i] !== 1'b0 || gotDone[i] !== 1'b0 || gotRd1[i] !== 32'd0) begin
                errors++;
                $display("[TB] FAIL reset_mid_clear inst%0d: got busy=%b done=%b rd1=%h expected 0",
                         i, gotBusy[i], gotDone[i], gotRd1[i]);
            end
        end
        #1;
        rst_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            Sr1 = 3'(a);
            Sr2 = 3'(7 - a);
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (gotDone[i] !== 1'b0 || gotBusy[i] !== 1'b0 || gotRd1[i] !== 32'd0 || gotRd2[i] !== 32'd0) begin
                    errors++;
                    $display("[TB] FAIL post_abort inst%0d a%0d: got busy=%b done=%b rd=%h/%h expected 0",
                             i, a, gotBusy[i], gotDone[i], gotRd1[i], gotRd2[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            write  = $urandom_range(0, 1) == 1;
            clear  = $urandom_range(0, 39) == 0;
            dr     = 3'($urandom_range(0, 7));
            Sr1    = ($urandom_range(0, 3) == 0) ? dr : 3'($urandom_range(0, 7));
            Sr2    = 3'($urandom_range(0, 7));
            wrData = $urandom;
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (gotRd1[i] !== eRd1[i] || gotRd2[i] !== eRd2[i] || gotBusy[i] !== eBusy[i] || gotDone[i] !== eDone[i]) begin
                    errors++;
                    $display("[TB] FAIL random inst%0d c%0d: got rd=%h/%h busy=%b done=%b expected %h/%h %b %b",
                             i, c, gotRd1[i], gotRd2[i], gotBusy[i], gotDone[i], eRd1[i], eRd2[i], eBusy[i], eDone[i]);
                end
            end
        end
        write = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        modelReset();
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_clear();
        test_clear_held();
        test_reset_mid_clear();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
